loba_expand_16: RTL and testbench
=================================

LOBA_EXPAND_16 -- requirements
Module: loba_expand_16

Interface
REQ-001 SHALL have parameter K, default 4: width of the truncated segment; legal range 2..8.
REQ-002 SHALL have parameter COMP, default 1: when 1, insert the half-LSB compensation bit (REQ-013).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-007 SHALL have port lob, input, 16 bits: one-hot leading-one word from the 16-bit leading-one detector.
REQ-008 SHALL have port seg, input, K bits: operand bits starting at the leading one, MSB-first; seg[K-1] is the leading one.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have ports y (output, 16 bits: reconstructed approximate operand), zero (output, 1 bit: lob was all-zero) and err (output, 1 bit: lob had more than one bit set).

Function
REQ-012 SHALL run a two-stage pipeline.
- S1 encodes lob to a 4-bit index p, detects zero and multi-hot, and registers p, seg, zero and err.
- S2 shifts and registers y, zero and err.
REQ-013 SHALL compute y in S2 as follows.
- If p >= K-1: y = seg << (p-(K-1)).
- If p < K-1: y = seg >> ((K-1)-p).
- If COMP=1 and p > K-1: also set y[p-K].
REQ-014 SHALL force y=0 and zero=1 when lob=0, with err=0 and no compensation bit.
REQ-015 SHALL force y=0 and err=1 when lob has two or more bits set, with zero=0.
REQ-016 SHALL not check seg[K-1]; y is computed from seg as given.
REQ-017 SHALL accept a beat when in_valid && in_ready.
REQ-018 SHALL transfer a result when out_valid && out_ready.
REQ-019 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when out_ready stays high.
REQ-020 SHALL sustain one beat per cycle with no bubbles.
REQ-021 SHALL define each stage as advancing when it is empty or the next stage advances.
- S2 advances when !out_valid || out_ready.
- in_ready = !s1_valid || S2 advances.
REQ-022 SHALL hold y, zero, err and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL, when the pipeline is full and out_ready is low, deassert in_ready in the same cycle; no beat is dropped or duplicated.
REQ-024 SHALL, when out_ready rises with both stages full, transfer the S2 result, move S1 to S2 and accept a new beat, all in the same cycle.
REQ-025 SHALL ignore lob and seg while in_valid is low.
REQ-026 SHALL keep in_ready purely combinational from internal state and out_ready, with no dependence on in_valid.

Reset
REQ-027 SHALL, when rst=1 on a clock edge, clear both stage-valid flags, so out_valid=0, y=0, zero=0 and err=0 in the next cycle.
REQ-028 SHALL discard any beats in flight when reset is asserted mid-stream; no result for them ever appears.
REQ-029 SHALL drive in_ready=1 while rst=1 and on the first cycle after reset, but accept no beat on a cycle where rst=1.

Verification
REQ-030 SHALL cover basic expansion (K=4, COMP=1, out_ready=1): lob=16'h0400, seg=4'b1011 -> y=16'h05C0, zero=0, err=0, two cycles later.
REQ-031 SHALL cover the small-index cases (K=4, COMP=1).
- lob=16'h0004, seg=4'b1010 -> y=16'h0005.
- lob=16'h0008, seg=4'b1001 -> y=16'h0009, with no compensation bit.
REQ-032 SHALL cover the special inputs.
- lob=16'h0000 -> y=0, zero=1.
- lob=16'h0101 -> y=0, err=1.
- COMP=0, lob=16'h8000, seg=4'b1111 -> y=16'hF000.
REQ-033 SHALL cover backpressure: stream 8 back-to-back beats with out_ready toggling randomly -> in-order results identical to a reference model, none lost or duplicated, and outputs stable while stalled.
REQ-034 SHALL cover reset mid-stream: assert rst for 1 cycle with both stages full -> out_valid=0 the next cycle, and the stale beats never emerge.
REQ-035 SHALL cover exhaustive single-beat sweep: all 16 one-hot lob values x all 2^(K-1) seg values with seg[K-1]=1 -> y matches REQ-013 for K=4 and K=8.

Source files
------------

// File: rtl/loba_expand_16.sv
// Two-stage leading-one expander: turns a one-hot leading-one word plus the K-bit
// segment that follows it into an approximate 16-bit operand, with valid/ready flow.
module loba_expand_16 #(
  parameter int unsigned K    = 4,
  parameter int unsigned COMP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   lob,
  input  logic [K-1:0]  seg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   y,
  output logic          zero,
  output logic          err
);

  logic          s1_valid_q, s1_valid_d;
  logic [3:0]    s1_p_q, s1_p_d;
  logic [K-1:0]  s1_seg_q, s1_seg_d;
  logic          s1_zero_q, s1_zero_d;
  logic          s1_err_q, s1_err_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   y_q, y_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;

  logic          s1_adv;
  logic          s2_adv;
  logic [3:0]    p_enc;
  logic          lob_zero;
  logic          lob_multi;
  logic [15:0]   seg_ext;
  logic [15:0]   y_shift;
  logic [15:0]   comp_mask;
  logic [15:0]   y_calc;

  // Leading-one index encoder plus zero / multi-hot detection.
  always_comb begin
    p_enc = 4'd0;
    for (int i = 0; i < 16; i++) begin
      p_enc = p_enc | (lob[i] ? 4'(i) : 4'd0);
    end
    lob_zero  = (lob == 16'h0000);
    lob_multi = ((lob & (lob - 16'd1)) != 16'h0000);
  end

  // Stage handshakes; in_ready is held high during reset so the source never sees a stall.
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = rst || s1_adv;
  end

  // Expansion: place the segment so its leading bit lands on index p, then add the half-LSB.
  always_comb begin
    seg_ext   = 16'(s1_seg_q);
    y_shift   = (s1_p_q >= 4'(K - 1)) ? (seg_ext << (s1_p_q - 4'(K - 1)))
                                      : (seg_ext >> (4'(K - 1) - s1_p_q));
    comp_mask = ((COMP == 1) && (s1_p_q > 4'(K - 1))) ? (16'h0001 << (s1_p_q - 4'(K)))
                                                      : 16'h0000;
    y_calc    = (s1_zero_q || s1_err_q) ? 16'h0000 : (y_shift | comp_mask);
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_p_d      = s1_p_q;
    s1_seg_d    = s1_seg_q;
    s1_zero_d   = s1_zero_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    err_d       = err_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_p_d    = p_enc;
        s1_seg_d  = seg;
        s1_zero_d = lob_zero;
        s1_err_d  = lob_multi;
      end else begin
        s1_p_d    = s1_p_q;
        s1_seg_d  = s1_seg_q;
        s1_zero_d = s1_zero_q;
        s1_err_d  = s1_err_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d    = y_calc;
        zero_d = s1_zero_q;
        err_d  = s1_err_q;
      end else begin
        y_d    = y_q;
        zero_d = zero_q;
        err_d  = err_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_p_q      <= 4'd0;
      s1_seg_q    <= '0;
      s1_zero_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= 16'h0000;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_p_q      <= s1_p_d;
      s1_seg_q    <= s1_seg_d;
      s1_zero_q   <= s1_zero_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_loba_expand_16.sv
// Bench for loba_expand_16: three configurations in lockstep against an arithmetic model.
module tb_loba_expand_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] lob;
  logic [3:0]  seg4;
  logic [7:0]  seg8;

  logic        ir_a, ov_a, z_a, e_a;
  logic [15:0] y_a;
  logic        ir_b, ov_b, z_b, e_b;
  logic [15:0] y_b;
  logic        ir_c, ov_c, z_c, e_c;
  logic [15:0] y_c;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] l;
    logic [3:0]  s4;
    logic [7:0]  s8;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  loba_expand_16 #(.K(4), .COMP(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .lob(lob), .seg(seg4),
    .out_valid(ov_a), .out_ready(out_ready), .y(y_a), .zero(z_a), .err(e_a));
  loba_expand_16 #(.K(8), .COMP(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .lob(lob), .seg(seg8),
    .out_valid(ov_b), .out_ready(out_ready), .y(y_b), .zero(z_b), .err(e_b));
  loba_expand_16 #(.K(4), .COMP(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .lob(lob), .seg(seg4),
    .out_valid(ov_c), .out_ready(out_ready), .y(y_c), .zero(z_c), .err(e_c));

  // Reference: {zero, err, y} from the value interpretation seg * 2^(p-(K-1)).
  function automatic logic [17:0] model(input int k, input int comp, input logic [15:0] l,
                                        input logic [7:0] s);
    int  ones = 0;
    int  p = 0;
    int  sv;
    int  v;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) begin
        ones++;
        p = i;
      end
    end
    if (ones == 0) return {1'b1, 1'b0, 16'h0000};
    if (ones > 1) return {1'b0, 1'b1, 16'h0000};
    sv = int'(s) % (1 << k);
    if (p >= k - 1) v = sv * (1 << (p - k + 1));
    else v = sv / (1 << (k - 1 - p));
    if (comp == 1 && p > k - 1) v = v + (1 << (p - k));
    return {2'b00, 16'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] l, input logic [3:0] s4,
                           input logic [7:0] s8);
    chk({tag, "_a"}, 32'({z_a, e_a, y_a}), 32'(model(4, 1, l, {4'h0, s4})));
    chk({tag, "_b"}, 32'({z_b, e_b, y_b}), 32'(model(8, 1, l, s8)));
    chk({tag, "_c"}, 32'({z_c, e_c, y_c}), 32'(model(4, 0, l, {4'h0, s4})));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat with out_ready high: checks the two-cycle latency and the result.
  task automatic single(input logic [15:0] l, input logic [3:0] s4, input logic [7:0] s8,
                        input string tag);
    in_valid = 1'b1;
    lob = l;
    seg4 = s4;
    seg8 = s8;
    #1;
    chk({tag, "_rdy"}, 32'(ir_a), 32'd1);
    step();
    in_valid = 1'b0;
    lob = 16'($urandom);
    seg4 = 4'($urandom);
    seg8 = 8'($urandom);
    #1;
    chk({tag, "_lat1"}, 32'(ov_a), 32'd0);
    step();
    chk({tag, "_ov"}, 32'({ov_a, ov_b, ov_c}), 32'd7);
    check_all(tag, l, s4, s8);
  endtask

  task automatic stream(input int nbeats, input bit rand_ready, input string tag);
    int    sent = 0;
    int    got = 0;
    int    cyc = 0;
    bit    pend = 1'b0;
    bit    held = 1'b0;
    int    r;
    int    a;
    beat_t cur;
    beat_t bt;
    logic [53:0] saved;
    exp_q.delete();
    while ((sent < nbeats || exp_q.size() != 0) && cyc < 400) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!pend && sent < nbeats) begin
        r = int'($urandom_range(0, 9));
        a = int'($urandom_range(0, 15));
        if (r == 0) cur.l = 16'h0000;
        else if (r == 1) cur.l = (16'h0001 << a) | (16'h0001 << ((a + 1 + int'($urandom_range(0, 14))) % 16));
        else cur.l = 16'h0001 << a;
        cur.s4 = 4'($urandom);
        cur.s8 = 8'($urandom);
        pend = 1'b1;
      end
      in_valid = pend;
      lob = pend ? cur.l : 16'($urandom);
      seg4 = pend ? cur.s4 : 4'($urandom);
      seg8 = pend ? cur.s8 : 8'($urandom);
      #1;
      chk({tag, "_inready"}, 32'(ir_a), (exp_q.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
      if (held) begin
        chk({tag, "_stall"}, 32'(ov_a), 32'd1);
        chk({tag, "_hold"}, 32'({z_a, e_a, y_a, z_b, e_b, y_b}), 32'(saved[35:0]));
        chk({tag, "_hold_c"}, 32'({z_c, e_c, y_c}), 32'(saved[53:36]));
      end
      if (ov_a && out_ready) begin
        chk({tag, "_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          bt = exp_q.pop_front();
          check_all(tag, bt.l, bt.s4, bt.s8);
          got++;
        end
        held = 1'b0;
      end else if (ov_a) begin
        held = 1'b1;
        saved = {z_c, e_c, y_c, z_a, e_a, y_a, z_b, e_b, y_b};
      end else begin
        held = 1'b0;
      end
      if (in_valid && ir_a) begin
        exp_q.push_back(cur);
        sent++;
        pend = 1'b0;
      end
      step();
      cyc++;
    end
    chk({tag, "_count"}, 32'(got), 32'(nbeats));
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    if (!rand_ready) chk({tag, "_nobubble"}, 32'(cyc), 32'(nbeats + 2));
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    lob = 16'h0400;
    seg4 = 4'hB;
    seg8 = 8'hB0;
    step();
    chk("rst_inready", 32'(ir_a), 32'd1);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_state", 32'({ov_a, z_a, e_a, y_a}), 32'd0);
    chk("rst_state_b", 32'({ov_b, z_b, e_b, y_b}), 32'd0);
    chk("post_rst_inready", 32'(ir_a), 32'd1);
    step();
    chk("rst_no_accept", 32'(ov_a), 32'd0);

    single(16'h0400, 4'b1011, 8'hB0, "basic");
    chk("basic_y", 32'(y_a), 32'h05C0);
    single(16'h0004, 4'b1010, 8'hA0, "small_p2");
    chk("small_p2_y", 32'(y_a), 32'h0005);
    single(16'h0008, 4'b1001, 8'h90, "small_p3");
    chk("small_p3_y", 32'(y_a), 32'h0009);
    single(16'h0000, 4'b1101, 8'hD5, "zero_in");
    chk("zero_flags", 32'({z_a, e_a, y_a}), 32'h20000);
    single(16'h0101, 4'b1101, 8'hD5, "multi_in");
    chk("multi_flags", 32'({z_a, e_a, y_a}), 32'h10000);
    single(16'h8000, 4'b1111, 8'hFF, "top_p15");
    chk("nocomp_y", 32'(y_c), 32'hF000);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 128; j++) begin
        single(16'h0001 << i, {1'b1, 3'(j)}, {1'b1, 7'(j)}, "sweep");
      end
    end

    step();
    stream(8, 1'b0, "b2b");
    stream(8, 1'b1, "bp8");
    stream(40, 1'b1, "bp40");

    out_ready = 1'b0;
    in_valid = 1'b1;
    lob = 16'h0000;
    seg4 = 4'h9;
    seg8 = 8'h91;
    step();
    lob = 16'h0020;
    step();
    chk("full_ov", 32'(ov_a), 32'd1);
    chk("full_inready", 32'(ir_a), 32'd0);
    chk("full_zero", 32'(z_a), 32'd1);
    rst = 1'b1;
    lob = 16'h0002;
    #1;
    chk("midrst_inready", 32'(ir_a), 32'd1);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_clear", 32'({ov_a, z_a, e_a, y_a}), 32'd0);
    chk("midrst_inready1", 32'(ir_a), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_stale", 32'({ov_a, ov_b, ov_c}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
